// File: rtl/ps2_keyboard_ctrl_pkg.sv
// Shared types, scan-code constants and the scan-code to ASCII table for the
// PS/2 keyboard front end. Shifted letters/digits are produced by lut() when
// its shift argument is set; the top only sets it in the SHIFT_CASE_EN build.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } dec_state_t;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;

   // Set-2 make code to ASCII; unmapped codes give 0x00.
   function automatic logic [7:0] lut(input logic [7:0] code, input logic shift);
      logic [7:0] a;
      case (code)
         8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
         8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
         8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
         8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
         8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
         8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
         8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
         8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
         8'h3E: a = 8'h38; 8'h46: a = 8'h39;
         8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08; 8'h0D: a = 8'h09;
         default: a = 8'h00;
      endcase
      if (shift) begin
         case (a)
            8'h30: a = 8'h29; 8'h31: a = 8'h21; 8'h32: a = 8'h40; 8'h33: a = 8'h23;
            8'h34: a = 8'h24; 8'h35: a = 8'h25; 8'h36: a = 8'h5E; 8'h37: a = 8'h26;
            8'h38: a = 8'h2A; 8'h39: a = 8'h28;
            default: begin
               if (a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
               else a = a;
            end
         endcase
      end else begin
         a = a;
      end
      return a;
   endfunction

endpackage

// File: rtl/ps2_keyboard_ctrl_if.sv
// Pin and display-side bundle of the PS/2 keyboard controller.
// master: the keyboard/display environment; slave: the controller.
interface ps2_keyboard_ctrl_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] make_code;
   logic [7:0] ascii;
   logic [7:0] count;
   logic       key_down;
   logic       frame_err;
   logic       overflow;

   modport master (
      output ps2_clk, ps2_data,
      input  make_code, ascii, count, key_down, frame_err, overflow
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output make_code, ascii, count, key_down, frame_err, overflow
   );
endinterface

// File: rtl/ps2_keyboard_ctrl_rx.sv
// PS/2 receiver: two-flop synchronizers, falling-edge detect on the synced
// clock, 11-bit deframing, start/stop/odd-parity check and mid-frame timeout.
// rx_valid / rx_err are one-cycle pulses on the cycle after the stop-bit edge.
module ps2_rx #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]      clk_sync_r, data_sync_r;
   logic            clk_prev_r;
   logic            fall_s;
   logic [3:0]      bit_cnt_r, bit_cnt_nx_s;
   logic [10:0]     frame_r, frame_nx_s, frame_shift_s;
   logic [TO_W-1:0] idle_cnt_r, idle_cnt_nx_s;
   logic [7:0]      byte_r, byte_nx_s;
   logic            valid_r, valid_nx_s, err_r, err_nx_s;
   logic            good_s;

   assign fall_s        = clk_prev_r & ~clk_sync_r[1];
   assign frame_shift_s = {data_sync_r[1], frame_r[10:1]};
   assign good_s        = ~frame_shift_s[0] & frame_shift_s[10] & (^frame_shift_s[9:1]);

   // Synchronize the pins (idle high) and keep one flop of clock history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_r  <= 2'b11;
         data_sync_r <= 2'b11;
         clk_prev_r  <= 1'b1;
      end else begin
         clk_sync_r  <= {clk_sync_r[0], ps2_clk};
         data_sync_r <= {data_sync_r[0], ps2_data};
         clk_prev_r  <= clk_sync_r[1];
      end
   end

   // Next-state for bit counter, shift register, idle timer and result pulses.
   always_comb begin
      bit_cnt_nx_s  = bit_cnt_r;
      frame_nx_s    = frame_r;
      idle_cnt_nx_s = idle_cnt_r;
      byte_nx_s     = byte_r;
      valid_nx_s    = 1'b0;
      err_nx_s      = 1'b0;
      if (fall_s) begin
         frame_nx_s    = frame_shift_s;
         idle_cnt_nx_s = '0;
         if (bit_cnt_r == 4'd10) begin
            bit_cnt_nx_s = 4'd0;
            if (good_s) begin
               valid_nx_s = 1'b1;
               byte_nx_s  = frame_shift_s[8:1];
            end else begin
               err_nx_s = 1'b1;
            end
         end else begin
            bit_cnt_nx_s = bit_cnt_r + 4'd1;
         end
      end else if (bit_cnt_r != 4'd0) begin
         if (idle_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
            bit_cnt_nx_s  = 4'd0;
            idle_cnt_nx_s = '0;
         end else begin
            idle_cnt_nx_s = idle_cnt_r + TO_W'(1);
         end
      end else begin
         idle_cnt_nx_s = '0;
      end
   end

   // Deframer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_r  <= 4'd0;
         frame_r    <= 11'd0;
         idle_cnt_r <= '0;
         byte_r     <= 8'h00;
         valid_r    <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         bit_cnt_r  <= bit_cnt_nx_s;
         frame_r    <= frame_nx_s;
         idle_cnt_r <= idle_cnt_nx_s;
         byte_r     <= byte_nx_s;
         valid_r    <= valid_nx_s;
         err_r      <= err_nx_s;
      end
   end

   assign rx_byte  = byte_r;
   assign rx_valid = valid_r;
   assign rx_err   = err_r;
endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard controller top: receiver, byte FIFO and make/break decoder.
// Optional feature macro: SHIFT_CASE_EN (left/right shift tracking that
// switches ASCII to uppercase letters and shifted digit symbols).
module ps2_keyboard_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input logic clk,
   input logic rst,
   ps2_keyboard_ctrl_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [7:0]  rx_byte_s;
   logic        rx_valid_s, rx_err_s;

   logic [7:0]  mem_r [FIFO_DEPTH];
   logic [AW:0] wr_ptr_r, rd_ptr_r;
   logic        full_s, empty_s, wr_en_s, pop_s;
   logic [7:0]  rd_byte_s;
   logic        overflow_r;

   // Decoder hold point; tied inactive in normal operation.
   logic        dec_stall_s;
   assign dec_stall_s = 1'b0;

   dec_state_t  state_r, state_nx_s;
   logic [7:0]  make_code_r, make_code_nx_s, ascii_r, ascii_nx_s, count_r, count_nx_s;
   logic        key_down_r, key_down_nx_s;
   logic        is_shift_s, shift_on_s;

   ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (bus.ps2_clk),
      .ps2_data (bus.ps2_data),
      .rx_byte  (rx_byte_s),
      .rx_valid (rx_valid_s),
      .rx_err   (rx_err_s)
   );

   assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign wr_en_s   = rx_valid_s & ~full_s;
   assign pop_s     = ~empty_s & ~dec_stall_s;
   assign rd_byte_s = mem_r[rd_ptr_r[AW-1:0]];

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= rx_byte_s;
      else         mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
   end

   // FIFO pointers and sticky overflow on a dropped byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
         if (rx_valid_s && full_s) overflow_r <= 1'b1;
      end
   end

`ifdef SHIFT_CASE_EN
   logic shift_lf_r, shift_lf_nx_s, shift_rt_r, shift_rt_nx_s;

   assign is_shift_s = (rd_byte_s == PS2_LSHIFT) || (rd_byte_s == PS2_RSHIFT);
   assign shift_on_s = shift_lf_r | shift_rt_r;

   // Shift flags: set on make, cleared on break, in both plain and extended form.
   always_comb begin
      shift_lf_nx_s = shift_lf_r;
      shift_rt_nx_s = shift_rt_r;
      if (pop_s && rd_byte_s != PS2_BREAK) begin
         case (state_r)
            ST_IDLE, ST_EXT: begin
               if (rd_byte_s == PS2_LSHIFT) shift_lf_nx_s = 1'b1;
               else if (rd_byte_s == PS2_RSHIFT) shift_rt_nx_s = 1'b1;
               else shift_lf_nx_s = shift_lf_r;
            end
            ST_BRK, ST_EXT_BRK: begin
               if (rd_byte_s == PS2_LSHIFT) shift_lf_nx_s = 1'b0;
               else if (rd_byte_s == PS2_RSHIFT) shift_rt_nx_s = 1'b0;
               else shift_lf_nx_s = shift_lf_r;
            end
            default: shift_lf_nx_s = shift_lf_r;
         endcase
      end else begin
         shift_lf_nx_s = shift_lf_r;
      end
   end

   // Shift flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_lf_r <= 1'b0;
         shift_rt_r <= 1'b0;
      end else begin
         shift_lf_r <= shift_lf_nx_s;
         shift_rt_r <= shift_rt_nx_s;
      end
   end
`else
   assign is_shift_s = 1'b0;
   assign shift_on_s = 1'b0;
`endif

   // Decoder next state and output values for the popped byte.
   always_comb begin
      state_nx_s     = state_r;
      make_code_nx_s = make_code_r;
      ascii_nx_s     = ascii_r;
      count_nx_s     = count_r;
      key_down_nx_s  = key_down_r;
      if (pop_s) begin
         case (state_r)
            ST_IDLE, ST_EXT: begin
               if (rd_byte_s == PS2_BREAK) begin
                  state_nx_s = (state_r == ST_IDLE) ? ST_BRK : ST_EXT_BRK;
               end else if (state_r == ST_IDLE && rd_byte_s == PS2_EXT) begin
                  state_nx_s = ST_EXT;
               end else begin
                  state_nx_s = ST_IDLE;
                  if (is_shift_s || (key_down_r && rd_byte_s == make_code_r)) begin
                     make_code_nx_s = make_code_r;
                  end else begin
                     make_code_nx_s = rd_byte_s;
                     ascii_nx_s     = (state_r == ST_EXT) ? 8'h00 : lut(rd_byte_s, shift_on_s);
                     key_down_nx_s  = 1'b1;
                     count_nx_s     = count_r + 8'd1;
                  end
               end
            end
            ST_BRK, ST_EXT_BRK: begin
               state_nx_s = ST_IDLE;
               if (!is_shift_s && rd_byte_s == make_code_r) key_down_nx_s = 1'b0;
               else key_down_nx_s = key_down_r;
            end
            default: state_nx_s = ST_IDLE;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Decoder state and registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         make_code_r <= 8'h00;
         ascii_r     <= 8'h00;
         count_r     <= 8'h00;
         key_down_r  <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         make_code_r <= make_code_nx_s;
         ascii_r     <= ascii_nx_s;
         count_r     <= count_nx_s;
         key_down_r  <= key_down_nx_s;
      end
   end

   assign bus.make_code = make_code_r;
   assign bus.ascii     = ascii_r;
   assign bus.count     = count_r;
   assign bus.key_down  = key_down_r;
   assign bus.frame_err = rx_err_s;
   assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Directed bench for ps2_keyboard_ctrl: bit-bangs PS/2 frames on the pins and
// compares the display outputs against hand-computed values.
module tb_ps2_keyboard_ctrl;
   localparam int H = 6;   // clk cycles per PS/2 clock half period

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ps2_keyboard_ctrl_if bus();

   ps2_keyboard_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYC(200)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int err_pulses = 0;

   // Count frame_err pulses.
   always @(posedge clk) begin
      if (bus.frame_err === 1'b1) err_pulses <= err_pulses + 1;
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
      return {1'b1, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] fr, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = fr[i];
         repeat (H) @(negedge clk);
         bus.ps2_clk = 1'b0;
         repeat (H) @(negedge clk);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(make_frame(b, 1'b0), 11);
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   int e0;
   logic [10:0] fr;

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_make", {8'h0, bus.make_code}, 16'h0000);
      check_eq("rst_ascii", {8'h0, bus.ascii}, 16'h0000);
      check_eq("rst_count", {8'h0, bus.count}, 16'h0000);
      check_eq("rst_flags", {13'h0, bus.key_down, bus.frame_err, bus.overflow}, 16'h0000);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // First press 0x1C with exact latency from the stop-bit clock fall.
      fr = make_frame(8'h1C, 1'b0);
      send_bits(fr, 10);
      bus.ps2_data = 1'b1;
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("lat_before", {8'h0, bus.make_code}, 16'h0000);
      @(negedge clk);
      check_eq("lat_make", {8'h0, bus.make_code}, 16'h001C);
      repeat (H - 5) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("a_ascii", {8'h0, bus.ascii}, 16'h0061);
      check_eq("a_count", {8'h0, bus.count}, 16'h0001);
      check_eq("a_down", {15'h0, bus.key_down}, 16'h0001);

      // Typematic repeat then release.
      for (int i = 0; i < 3; i++) send_byte(8'h1C);
      check_eq("typ_count", {8'h0, bus.count}, 16'h0001);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check_eq("brk_down", {15'h0, bus.key_down}, 16'h0000);
      check_eq("brk_make", {8'h0, bus.make_code}, 16'h001C);
      check_eq("brk_ascii", {8'h0, bus.ascii}, 16'h0061);
      check_eq("brk_count", {8'h0, bus.count}, 16'h0001);

      // Parity error, then the same code correctly framed.
      e0 = err_pulses;
      send_bits(make_frame(8'h32, 1'b1), 11);
      repeat (10) @(negedge clk);
      check_eq("perr_pulses", 16'(err_pulses - e0), 16'h0001);
      check_eq("perr_make", {8'h0, bus.make_code}, 16'h001C);
      check_eq("perr_count", {8'h0, bus.count}, 16'h0001);
      send_byte(8'h32);
      check_eq("b_make", {8'h0, bus.make_code}, 16'h0032);
      check_eq("b_ascii", {8'h0, bus.ascii}, 16'h0062);
      check_eq("b_count", {8'h0, bus.count}, 16'h0002);

      // Extended make and extended break.
      send_byte(8'hE0);
      send_byte(8'h75);
      check_eq("ext_make", {8'h0, bus.make_code}, 16'h0075);
      check_eq("ext_ascii", {8'h0, bus.ascii}, 16'h0000);
      check_eq("ext_count", {8'h0, bus.count}, 16'h0003);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      check_eq("extbrk_down", {15'h0, bus.key_down}, 16'h0000);
      check_eq("extbrk_make", {8'h0, bus.make_code}, 16'h0075);

      // Abandoned partial frame is dropped by the timeout.
      e0 = err_pulses;
      send_bits(make_frame(8'h1C, 1'b0), 4);
      repeat (300) @(negedge clk);
      send_byte(8'h1D);
      check_eq("to_make", {8'h0, bus.make_code}, 16'h001D);
      check_eq("to_ascii", {8'h0, bus.ascii}, 16'h0077);
      check_eq("to_count", {8'h0, bus.count}, 16'h0004);
      check_eq("to_err", 16'(err_pulses - e0), 16'h0000);

      // Count wrap over 256 alternating presses.
      do_reset();
      for (int i = 0; i < 255; i++) send_byte((i % 2 == 0) ? 8'h1C : 8'h1B);
      check_eq("wrap_ff", {8'h0, bus.count}, 16'h00FF);
      send_byte(8'h1B);
      check_eq("wrap_00", {8'h0, bus.count}, 16'h0000);
      check_eq("wrap_make", {8'h0, bus.make_code}, 16'h001B);
      check_eq("wrap_ascii", {8'h0, bus.ascii}, 16'h0073);

      // Overflow: 9 bytes into an 8-deep FIFO with the decoder held.
      force dut.dec_stall_s = 1'b1;
      send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24);
      send_byte(8'h2D); send_byte(8'h2C); send_byte(8'h35);
      send_byte(8'h3C); send_byte(8'h43); send_byte(8'h44);
      check_eq("ovf_set", {15'h0, bus.overflow}, 16'h0001);
      check_eq("ovf_held", {8'h0, bus.count}, 16'h0000);
      release dut.dec_stall_s;
      repeat (20) @(negedge clk);
      check_eq("ovf_make", {8'h0, bus.make_code}, 16'h0043);
      check_eq("ovf_ascii", {8'h0, bus.ascii}, 16'h0069);
      check_eq("ovf_count", {8'h0, bus.count}, 16'h0008);
      check_eq("ovf_sticky", {15'h0, bus.overflow}, 16'h0001);

      // Reset in the middle of a frame.
      e0 = err_pulses;
      send_bits(make_frame(8'h2C, 1'b0), 6);
      do_reset();
      check_eq("mrst_ovf", {15'h0, bus.overflow}, 16'h0000);
      check_eq("mrst_count", {8'h0, bus.count}, 16'h0000);
      send_byte(8'h2B);
      check_eq("mrst_make", {8'h0, bus.make_code}, 16'h002B);
      check_eq("mrst_ascii", {8'h0, bus.ascii}, 16'h0066);
      check_eq("mrst_cnt1", {8'h0, bus.count}, 16'h0001);
      check_eq("mrst_err", 16'(err_pulses - e0), 16'h0000);

`ifdef SHIFT_CASE_EN
      send_byte(8'h12);
      check_eq("sh_count", {8'h0, bus.count}, 16'h0001);
      check_eq("sh_make", {8'h0, bus.make_code}, 16'h002B);
      send_byte(8'h1C);
      check_eq("sh_ascii", {8'h0, bus.ascii}, 16'h0041);
      check_eq("sh_count2", {8'h0, bus.count}, 16'h0002);
      send_byte(8'h16);
      check_eq("sh_digit", {8'h0, bus.ascii}, 16'h0021);
      send_byte(8'hF0);
      send_byte(8'h12);
      send_byte(8'h1C);
      check_eq("unsh_ascii", {8'h0, bus.ascii}, 16'h0061);
`else
      send_byte(8'h12);
      check_eq("ns_make", {8'h0, bus.make_code}, 16'h0012);
      check_eq("ns_ascii", {8'h0, bus.ascii}, 16'h0000);
      check_eq("ns_count", {8'h0, bus.count}, 16'h0002);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
